// File: rtl/rf_loader_if.sv
// rf_loader_if: start/stream/register-file bundle between a loader and its environment
interface rf_loader_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   count;
  logic              abort;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              RegWrite;
  logic [ADDR_W-1:0] wa;
  logic [DATA_W-1:0] wd;
  logic              busy;
  logic              done;
  logic              err;
  modport master (
    output start, base_addr, count, abort, in_valid, in_data,
    input  in_ready, RegWrite, wa, wd, busy, done, err
  );
  modport slave (
    input  start, base_addr, count, abort, in_valid, in_data,
    output in_ready, RegWrite, wa, wd, busy, done, err
  );
endinterface

// File: rtl/rf_loader.sv
// rf_loader: streams count words into consecutive register-file addresses from base_addr
module rf_loader #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) (
  input logic        clk,
  input logic        rst,
  rf_loader_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
  localparam logic [ADDR_W:0] MAX_CNT = (ADDR_W+1)'(1) << ADDR_W;
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d, wa_q, wa_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] wd_q, wd_d;
  logic              we_q, we_d, err_q, err_d, legal, accept;
  assign legal        = bus.count != '0 && bus.count <= MAX_CNT;
  assign bus.in_ready = state_q == LOAD && !bus.abort;
  assign accept       = bus.in_valid && bus.in_ready;
  assign bus.RegWrite = we_q;
  assign bus.wa       = wa_q;
  assign bus.wd       = wd_q;
  assign bus.err      = err_q;
  assign bus.done     = state_q == DONE;
  assign bus.busy     = state_q != IDLE;
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    err_d   = state_q == IDLE && bus.start && !legal;
    we_d    = accept;
    wa_d    = accept ? ptr_q : wa_q;
    wd_d    = accept ? bus.in_data : wd_q;
    if (state_q == IDLE && bus.start && legal) begin
      state_d = LOAD;
      ptr_d   = bus.base_addr;
      cnt_d   = bus.count;
    end else if (state_q == LOAD && bus.abort) begin
      state_d = IDLE;
    end else if (accept) begin
      ptr_d   = ptr_q + 1'b1;
      cnt_d   = cnt_q - 1'b1;
      state_d = cnt_q == (ADDR_W+1)'(1) ? DONE : LOAD;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      wa_q    <= '0;
      wd_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      wa_q    <= wa_d;
      wd_q    <= wd_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: doc/rf_loader.md
RF_LOADER -- requirements
Module: rf_loader

Interface
REQ-001 Parameter DATA_W, default 32, write-data width.
REQ-002 Parameter ADDR_W, default 4, register address width (2^ADDR_W = 16 registers).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  load request, sampled in IDLE only.
REQ-006 base_addr  input  ADDR_W  first register address, sampled with start.
REQ-007 count  input  ADDR_W+1  number of words to load, sampled with start; legal 1..16.
REQ-008 abort  input  1  terminate an active load.
REQ-009 in_valid  input  1  stream word valid.
REQ-010 in_data  input  DATA_W  stream word.
REQ-011 in_ready  output  1  loader accepts a word this cycle.
REQ-012 RegWrite  output  1  register-file write enable.
REQ-013 wa  output  ADDR_W  register-file write address.
REQ-014 wd  output  DATA_W  register-file write data.
REQ-015 busy  output  1  high in LOAD and DONE.
REQ-016 done  output  1  one-cycle pulse on load completion.
REQ-017 err  output  1  one-cycle pulse on an illegal start.

Function
REQ-018 States: IDLE, LOAD, DONE.
REQ-019 IDLE with start=1 and count in 1..16: latch base_addr into the address pointer and count into the remaining counter; next state LOAD.
REQ-020 IDLE with start=1 and count=0 or count>16: err=1 in the next cycle; state stays IDLE; nothing is latched.
REQ-021 in_ready = (state==LOAD) & ~abort, combinational; 0 in IDLE and DONE.
REQ-022 A beat is accepted when in_valid & in_ready at a rising edge.
REQ-023 On an accepted beat, the block registers RegWrite=1, wa=pointer and wd=in_data. These are visible for exactly the following cycle, so the register file captures the word at the next edge (1-cycle latency).
REQ-024 RegWrite=0 in every cycle not immediately following an accepted beat; wa and wd hold their last values when RegWrite=0.
REQ-025 Per accepted beat: pointer increments modulo 16 (15 wraps to 0) and the remaining counter decrements.
REQ-026 In LOAD with in_valid=0: no write occurs and no state changes (stall of any length).
REQ-027 The beat that brings the remaining counter to 0 moves the state to DONE; in DONE, done=1 for one cycle, then the state returns to IDLE.
REQ-028 The final write's RegWrite cycle coincides with the done cycle.
REQ-029 start is ignored outside IDLE.
REQ-030 abort=1 in LOAD: no beat is accepted that cycle; next state IDLE; done is not pulsed; the counter and pointer are not cleared (don't-care afterwards).
REQ-031 A write registered from a beat accepted before abort still completes (its RegWrite cycle is not cancelled).
REQ-032 abort is ignored in IDLE and DONE.
REQ-033 Back-to-back: start may be accepted in the IDLE cycle immediately after DONE.
REQ-034 busy = (state==LOAD) | (state==DONE).

Reset
REQ-035 rst=1 forces, asynchronously: state IDLE, RegWrite=0, wa=0, wd=0, done=0, err=0, busy=0, pointer=0, counter=0.
REQ-036 rst asserted mid-load drops any pending write (RegWrite=0 immediately); no done is generated.
REQ-037 After rst deasserts, the first start is sampled no earlier than the first rising edge.

Verification
REQ-038 start with base=3 and count=4; stream 0xA0..0xA3 with valid always high -> writes wa=3,4,5,6 with wd=A0..A3 on consecutive cycles; done pulses once with the last write; busy spans 5 cycles.
REQ-039 start with base=14 and count=4 -> wa sequence 14,15,0,1 (wrap).
REQ-040 start with count=6 and in_valid toggling 1,0,0,1,... -> exactly 6 writes, no write on stall cycles, addresses contiguous.
REQ-041 start with count=0, then start with count=17 -> err pulses each time; busy stays 0; no RegWrite.
REQ-042 start with count=8; abort after 3 beats -> exactly 3 writes; in_ready=0 during the abort cycle; no done; the next start with base=0 and count=1 is accepted normally.
REQ-043 rst pulse in the cycle after a beat is accepted -> RegWrite falls immediately; all outputs return to their reset values.
